// File: rtl/debounce_synchronizer_pkg.sv
// Shared types and helpers for the debounce synchronizer.
package sync_pkg;

    // Per-channel filter state.
    typedef enum logic {
        STABLE = 1'b0,
        FILTER = 1'b1
    } debounce_state_t;

    // Default synchronizer depth.
    localparam int DEFAULT_FLOP_NUMBER = 2;

    // Bits needed to count 0..cycles; never less than one bit so that the
    // pass-through configuration still has a legal vector width.
    function automatic int cnt_width(input int cycles);
        int w;
        w = 1;
        for (int b = 1; b < 31; b++) begin
            if ((1 << b) < (cycles + 1)) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_synchronizer_channel.sv
// One channel: flop-chain synchronizer, debounce filter and edge registers.
module debounce_channel
    import sync_pkg::*;
#(
    parameter int   FLOP_NUMBER     = DEFAULT_FLOP_NUMBER,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic signal_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o
);

    logic [FLOP_NUMBER-1:0] r_sync;
    logic                   r_data;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;
    logic                   w_data_next;

    assign w_sync = r_sync[FLOP_NUMBER-1];

    // Metastability chain: shift the raw input towards the last stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= {FLOP_NUMBER{RESET_BIT}};
        end else begin
            r_sync <= {r_sync[FLOP_NUMBER-2:0], signal_i};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_pass
            assign w_data_next = w_sync;
        end else begin : g_filter
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            debounce_state_t r_state;
            debounce_state_t w_state_next;
            logic [CW-1:0]   r_cnt;
            logic [CW-1:0]   w_cnt_next;
            logic            w_filt_data;

            // Count consecutive samples that disagree with the output; any
            // agreeing sample, even on the last count, cancels the change.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_filt_data  = r_data;
                case (r_state)
                    STABLE: begin
                        if (w_sync != r_data) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                w_filt_data = w_sync;
                            end else begin
                                w_state_next = FILTER;
                                w_cnt_next   = CW'(1);
                            end
                        end
                    end
                    FILTER: begin
                        if (w_sync == r_data) begin
                            w_state_next = STABLE;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_LAST) begin
                            w_filt_data  = w_sync;
                            w_state_next = STABLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        w_state_next = STABLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Filter state and counter registers; reset aborts any filtering.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_state <= STABLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            assign w_data_next = w_filt_data;
        end
    endgenerate

    // Output level plus edge pulses aligned with the first cycle of a new level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= RESET_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_rise <= w_data_next & ~r_data;
            r_fall <= ~w_data_next & r_data;
        end
    end

    assign data_o = r_data;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/debounce_synchronizer.sv
// Multi-channel debounced synchronizer with edge pulses and a maskable event flag.
module debounce_synchronizer
    import sync_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  FLOP_NUMBER     = DEFAULT_FLOP_NUMBER,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] signal_i,
    input  logic [CHANNELS-1:0] rise_en_i,
    input  logic [CHANNELS-1:0] fall_en_i,
    output logic [CHANNELS-1:0] data_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                event_o
);

    logic [CHANNELS-1:0] w_data;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic                r_event;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            debounce_channel #(
                .FLOP_NUMBER    (FLOP_NUMBER),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_BIT      (RESET_VALUE[gi])
            ) u_ch (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .signal_i(signal_i[gi]),
                .data_o  (w_data[gi]),
                .rise_o  (w_rise[gi]),
                .fall_o  (w_fall[gi])
            );
        end
    endgenerate

    // Collapse all enabled edge pulses of this cycle into one event pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_event <= 1'b0;
        end else begin
            r_event <= |((w_rise & rise_en_i) | (w_fall & fall_en_i));
        end
    end

    assign data_o  = w_data;
    assign rise_o  = w_rise;
    assign fall_o  = w_fall;
    assign event_o = r_event;

endmodule
